// File: rtl/sram_controller.sv
// Multi-cycle bridge from a 32-bit pipeline load/store port to a 16-bit asynchronous SRAM.
// Each word takes two half-word accesses (low then high), each held WAIT_CYCLES+1 cycles.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_val,
  output logic [31:0] readdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {StIdle, StAccLo, StAccHi, StDone} state_e;

  localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_is_wr, w_is_wr_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;

  logic        w_req;
  logic        w_last;
  logic [16:0] w_idx;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;
  logic        w_unused_addr;

  assign w_req  = MEM_R_EN | MEM_W_EN;
  assign w_last = (r_cnt == LastCnt);
  // (addr - 1024) >> 2 mod 2^17; base is word aligned so only bits [18:2] matter.
  assign w_idx  = ALU_result[18:2] - 17'd256;
  assign w_unused_addr = ^{ALU_result[31:19], ALU_result[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
      r_is_wr <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_wr <= w_is_wr_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_is_wr_nxt = r_is_wr;
    w_rdata_nxt = r_rdata;
    ready       = 1'b0;
    SRAM_ADDR   = 18'd0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = ST_val[15:0];

    unique case (r_state)
      StIdle: begin
        ready = ~w_req;
        if (w_req) begin
          w_state_nxt = StAccLo;
          w_cnt_nxt   = 3'd0;
          w_is_wr_nxt = MEM_W_EN;  // write wins when both are requested
        end
      end
      StAccLo: begin
        SRAM_ADDR = {w_idx, 1'b0};
        SRAM_WE_N = ~r_is_wr;
        SRAM_OE_N = r_is_wr;
        w_dq_oe   = r_is_wr;
        w_dq_out  = ST_val[15:0];
        if (w_last) begin
          w_state_nxt = StAccHi;
          w_cnt_nxt   = 3'd0;
          if (!r_is_wr) w_rdata_nxt[15:0] = SRAM_DQ;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      StAccHi: begin
        SRAM_ADDR = {w_idx, 1'b1};
        SRAM_WE_N = ~r_is_wr;
        SRAM_OE_N = r_is_wr;
        w_dq_oe   = r_is_wr;
        w_dq_out  = ST_val[31:16];
        if (w_last) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = 3'd0;
          if (!r_is_wr) w_rdata_nxt[31:16] = SRAM_DQ;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      StDone: begin
        ready       = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    if (!rst) ready = 1'b1;
  end

  assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
  assign readdata  = r_rdata;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
